// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel registered mux with fixed-select and round-robin modes.
// One output slot decouples producers from the consumer; in_ready is combinational.

module rr_mux_n_lane #(
    parameter int W    = 8,
    parameter int SELW = 3,
    parameter int ID   = 0
) (
    input  logic [SELW-1:0] gnt,
    input  logic            gnt_en,
    input  logic            load_ok,
    input  logic [W-1:0]    data,
    output logic            ready,
    output logic [W-1:0]    data_gated
);
    logic hit;

    assign hit        = gnt_en && (gnt == SELW'(ID));
    assign ready      = hit && load_ok;
    assign data_gated = hit ? data : '0;
endmodule

module rr_mux_n #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);
    logic                run;
    logic                load_ok;
    logic                gnt_en;
    logic                xfer;
    logic [SELW-1:0]     ptr;
    logic [SELW-1:0]     gnt;
    logic [N-1:0][W-1:0] gated;
    logic [W-1:0]        gnt_data;
    int                  idx;

    // run stays low until the first edge after reset so nothing loads on that edge
    assign load_ok = run && !rst && (!out_valid || out_ready);

    always_comb begin
        gnt    = '0;
        gnt_en = 1'b0;
        idx    = 0;
        if (!mode) begin
            gnt    = sel;
            gnt_en = ({1'b0, sel} < (SELW+1)'(N));
        end else begin
            // scan in reverse search order so the first valid channel after ptr wins
            for (int i = N-1; i >= 0; i--) begin
                idx = int'(ptr) + i;
                if (idx >= N) idx = idx - N;
                if (in_valid[idx]) begin
                    gnt    = SELW'(idx);
                    gnt_en = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        rr_mux_n_lane #(.W(W), .SELW(SELW), .ID(k)) u_lane (
            .gnt        (gnt),
            .gnt_en     (gnt_en),
            .load_ok    (load_ok),
            .data       (in[k*W +: W]),
            .ready      (in_ready[k]),
            .data_gated (gated[k])
        );
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N; k++) gnt_data = gnt_data | gated[k];
    end

    assign xfer = |(in_valid & in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            run       <= 1'b0;
        end else begin
            run <= 1'b1;
            if (xfer) begin
                out       <= gnt_data;
                out_ch    <= gnt;
                out_valid <= 1'b1;
                if (mode) ptr <= (gnt == SELW'(N-1)) ? '0 : gnt + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/rr_mux_n.md
# rr_mux_n

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the team's 8:1 bit multiplexer and supports two modes: fixed selection by `sel`, and round-robin arbitration among valid channels. It sits between several producer channels and one shared consumer. A single output register decouples them and sustains one transfer per cycle.

## Interface
- `N`, default 8: number of input channels, 2..16.
- `W`, default 8: data width per channel, 1..32.
- `SELW`, default `$clog2(N)`: select and channel-id width. Derived; do not override.

- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in`, input, N*W: packed channel data; channel k occupies `in[k*W +: W]`.
- `in_valid`, input, N: per-channel valid.
- `in_ready`, output, N: per-channel ready. Combinational; at most one bit high.
- `mode`, input, 1: 0 = fixed select, 1 = round-robin.
- `sel`, input, SELW: channel chosen in fixed mode. Ignored in round-robin mode.
- `out`, output, W: registered data.
- `out_ch`, output, SELW: channel index the `out` word came from.
- `out_valid`, output, 1: output register holds a word.
- `out_ready`, input, 1: consumer accepts `out` this cycle.

## Operation
- **Output slot.** One-entry register with contents {`out`, `out_ch`}.
  - `load_ok = !out_valid || out_ready`.
- **Grant, fixed mode.**
  - `grant = sel` when `sel < N`; `in_ready[sel] = load_ok`.
  - When `sel >= N`: all `in_ready` are 0 and nothing loads.
- **Grant, round-robin mode.**
  - A pointer `ptr` (SELW bits) marks the highest-priority channel.
  - `grant` is the first channel with `in_valid` high, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
  - `in_ready[grant] = load_ok`. If no channel is valid, all `in_ready` are 0.
- **Transfer.** A transfer on channel k occurs when `in_valid[k] && in_ready[k]`. At the next edge:
  - `out <= in[k*W +: W]`
  - `out_ch <= k`
  - `out_valid <= 1`
- **Pointer update.** Only on a round-robin transfer: `ptr <= (k == N-1) ? 0 : k+1`. This wrap is correct for non-power-of-2 N. Fixed-mode transfers leave `ptr` unchanged.
- **Drain.** When `out_valid && out_ready` with no transfer in the same cycle: `out_valid <= 0`. `out` and `out_ch` hold their last values.
- **Simultaneous drain and load.** The new word replaces the old one and `out_valid` stays 1, giving no bubble.
- **Stall.** While `out_valid && !out_ready`: all `in_ready` are 0, and `out`/`out_ch` are stable.
- **Mode or sel change.** Takes effect combinationally in the same cycle. A word already in the output slot is unaffected.
- **Data width.** Data passes through unmodified; there is no arithmetic on data.

## Timing
- **Reset values.** `out = 0`, `out_ch = 0`, `out_valid = 0`, `ptr = 0`.
- **`in_ready` during reset.** All 0 while `rst` is high, since `in_ready` is gated by `!rst`.
- **Reset mid-operation.** A held word is discarded immediately (asynchronously). No transfer occurs on the edge at which reset deasserts.
- **Latency.** 1 cycle from an input transfer edge to `out_valid` and data visible on the output.
- **Throughput.** 1 word per cycle while `out_ready` is held high.
- **Combinational paths.** `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_valid` and `out_ready`. No other outputs are combinational.
- **Input stability.** Producers must not depend on `in_ready` to drive `in_valid`; `in_valid` must not wait for `in_ready`.

## Test plan
- **Reset.** Assert `rst` mid-stream while `out_valid=1`, `out=8'hA5` → `out_valid`, `out` and `out_ch` go to 0 immediately. After release, `in_ready` stays 0 until the first edge.
- **Fixed mode sweep.** Set `mode=0`, `in[k]=8'h10+k`, all valid, `out_ready=1`; step `sel` 0..7 → one cycle later `out=8'h10+sel` and `out_ch=sel`. `sel=8` with N=9 behaves the same. `sel>=N` (N=6, `sel=7`) → no `in_ready` and `out_valid` falls.
- **Round-robin fairness.** Set `mode=1`, all 8 channels valid, `out_ready=1` → `out_ch` sequence 0,1,…,7,0 on consecutive cycles, with no bubbles.
- **Round-robin skip and wrap.** With N=6, only channels 2 and 5 valid, `ptr=3` → grants 5, then 2, then 5. After granting channel 5, `ptr` = 0.
- **Backpressure.** Hold `out_ready=0` for 4 cycles with `out=8'h33` → `out` stable, all `in_ready=0`. Raise `out_ready` with channel 1 valid (`8'h44`) → next cycle `out=8'h44`, with `out_valid` held high throughout.
- **Drain without load.** Set `out_valid=1`, `out_ready=1`, no inputs valid → `out_valid=0` next cycle, and `out` retains its last value.
